clock_divider_n: RTL

- Runtime-programmable integer clock divider; parametrised successor to the fixed divide-by-two flip-flop divider.
- Produces a registered divided output `out` (duty = floor(N/2)/N) and a one-cycle `tick` strobe at each period start.
- Output is a clock-enable-style signal for downstream synchronous logic. It is not a routed clock.
- Divisor changes are glitch-free: they take effect only at a period boundary.

---
 rtl/clkdiv_pkg.sv | 11 +
 rtl/clkdiv_counter.sv | 31 +++
 rtl/clock_divider_n.sv | 87 ++++++++
 3 files changed

// File: rtl/clkdiv_pkg.sv
// Shared definitions for the programmable clock-divider family.
// Holds the minimum legal divisor and the clamp helper used when a divisor is captured.
package clkdiv_pkg;

  localparam int unsigned CLKDIV_MIN_DIV = 2;

  function automatic int unsigned clkdiv_clamp(input int unsigned value);
    return (value < CLKDIV_MIN_DIV) ? CLKDIV_MIN_DIV : value;
  endfunction

endpackage

// File: rtl/clkdiv_counter.sv
// Modulo-N counter with enable and wrap flag; resets so the first enabled edge wraps to 0.
module clkdiv_counter
  import clkdiv_pkg::*;
#(
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div,
  output logic [DIV_WIDTH-1:0] cnt_next,
  output logic                 wrap
);

  logic [DIV_WIDTH-1:0] cnt;

  always_comb begin
    wrap     = (cnt == (div - DIV_WIDTH'(1)));
    cnt_next = wrap ? '0 : (cnt + DIV_WIDTH'(1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= DIV_WIDTH'(DEFAULT_DIV - 1);
    end else if (enable) begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/clock_divider_n.sv
// Runtime-programmable integer divider producing a registered enable-style output and tick.
// Optional macro CLKDIV_PENDING_EN exposes the pending-divisor flag as port `pending`.
module clock_divider_n
  import clkdiv_pkg::*;
#(
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] div_in,
  output logic                 out,
  output logic                 tick,
  output logic [DIV_WIDTH-1:0] active_div
`ifdef CLKDIV_PENDING_EN
  ,
  output logic                 pending
`endif
);

  logic [DIV_WIDTH-1:0] cnt_next;
  logic                 wrap;
  logic [DIV_WIDTH-1:0] half;
  logic [DIV_WIDTH-1:0] div_clamped;
  logic [DIV_WIDTH-1:0] pend;
  logic                 pend_valid;

  clkdiv_counter #(
    .DIV_WIDTH  (DIV_WIDTH),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) u_counter (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .div     (active_div),
    .cnt_next(cnt_next),
    .wrap    (wrap)
  );

  always_comb begin
    half        = active_div >> 1;
    div_clamped = DIV_WIDTH'(clkdiv_clamp(32'(div_in)));
  end

  // Pending divisor data carries no reset; pend_valid qualifies it.
  always_ff @(posedge clock) begin
    if (load) begin
      pend <= div_clamped;
    end
  end

  // A new divisor is only adopted at an enabled wrap, so a period is never cut short.
  always_ff @(posedge clock) begin
    if (reset) begin
      active_div <= DIV_WIDTH'(DEFAULT_DIV);
      pend_valid <= 1'b0;
    end else if (enable && wrap) begin
      if (load) begin
        active_div <= div_clamped;
      end else if (pend_valid) begin
        active_div <= pend;
      end
      pend_valid <= 1'b0;
    end else if (load) begin
      pend_valid <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out  <= 1'b0;
      tick <= 1'b0;
    end else if (enable) begin
      out  <= (cnt_next < half);
      tick <= (cnt_next == '0);
    end else begin
      tick <= 1'b0;
    end
  end

`ifdef CLKDIV_PENDING_EN
  assign pending = pend_valid;
`endif

endmodule
